// File: rtl/axi_arb_pkg.sv
// rtl/axi_arb_pkg.sv - shared types and encodings for the two-master AXI4-Lite memory arbiter
package axi_arb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4
    } arb_state_e;

    localparam logic GNT_M0  = 1'b0;
    localparam logic GNT_M1  = 1'b1;

    localparam logic KIND_RD = 1'b0;
    localparam logic KIND_WR = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational M0/M1 pick policy (round-robin when ARB_RR_EN is defined, else fixed M1 priority)
//
// Ports:
//   ptr_i  : round-robin pointer, 1 = prefer M1 (present only with ARB_RR_EN)
//   req_i  : request vector, bit 0 = M0, bit 1 = M1
//   gnt_o  : one-hot grant, all zero when nothing is requesting
module mem_arb_pick (
`ifdef ARB_RR_EN
    input  logic       ptr_i,
`endif
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

`ifdef ARB_RR_EN
    // A lone requester always wins; on contention the pointer decides.
    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = ptr_i ? 2'b10 : 2'b01;
        end
    end
`else
    // D-cache (M1) always beats I-cache (M0).
    always_comb begin
        gnt_o = req_i;
        if (req_i[1]) begin
            gnt_o = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/axi_mem_arbiter.sv
// rtl/axi_mem_arbiter.sv - shares one single-outstanding AXI4-Lite slave port between I-cache (M0, read) and D-cache (M1, read/write)
//
// Optional feature macro: ARB_RR_EN (round-robin pick; fixed M1 priority otherwise).
// Ports:
//   ACLK, ARESET           : clock, asynchronous active-high reset
//   M0_AR_*, M0_R_*        : I-cache read address / read data
//   M1_AR_*, M1_R_*        : D-cache read address / read data
//   M1_AW_*, M1_W_*, M1_B_*: D-cache write address / write data / write response
//   S_*                    : shared memory slave port
//   GNT                    : owner of the current transaction (0 = M0, 1 = M1)
module axi_mem_arbiter
    import axi_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                M0_AR_VALID,
    input  logic [ADDR_W-1:0]   M0_AR_ADDR,
    output logic                M0_AR_READY,
    output logic                M0_R_VALID,
    output logic [DATA_W-1:0]   M0_R_DATA,
    input  logic                M0_R_READY,
    input  logic                M1_AR_VALID,
    input  logic [ADDR_W-1:0]   M1_AR_ADDR,
    output logic                M1_AR_READY,
    output logic                M1_R_VALID,
    output logic [DATA_W-1:0]   M1_R_DATA,
    input  logic                M1_R_READY,
    input  logic                M1_AW_VALID,
    input  logic [ADDR_W-1:0]   M1_AW_ADDR,
    output logic                M1_AW_READY,
    input  logic                M1_W_VALID,
    input  logic [DATA_W-1:0]   M1_W_DATA,
    input  logic [DATA_W/8-1:0] M1_W_STRB,
    output logic                M1_W_READY,
    output logic                M1_B_VALID,
    input  logic                M1_B_READY,
    output logic                S_AR_VALID,
    output logic [ADDR_W-1:0]   S_AR_ADDR,
    input  logic                S_AR_READY,
    input  logic                S_R_VALID,
    input  logic [DATA_W-1:0]   S_R_DATA,
    output logic                S_R_READY,
    output logic                S_AW_VALID,
    output logic [ADDR_W-1:0]   S_AW_ADDR,
    input  logic                S_AW_READY,
    output logic                S_W_VALID,
    output logic [DATA_W-1:0]   S_W_DATA,
    output logic [DATA_W/8-1:0] S_W_STRB,
    input  logic                S_W_READY,
    input  logic                S_B_VALID,
    output logic                S_B_READY,
    output logic                GNT
);

    arb_state_e state_q;
    logic       gnt_q;
    logic       kind_q;
    logic       kind_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;
    logic [1:0] pick_gnt;
`ifdef ARB_RR_EN
    logic       ptr_q;
`endif

    mem_arb_pick u_pick (
`ifdef ARB_RR_EN
        .ptr_i (ptr_q),
`endif
        .req_i ({M1_AR_VALID | M1_AW_VALID, M0_AR_VALID}),
        .gnt_o (pick_gnt)
    );

    // An M1 write beats an M1 read of the same master.
    assign kind_d = (pick_gnt[1] && M1_AW_VALID) ? KIND_WR : KIND_RD;

    logic st_rd_addr, st_rd_data, st_wr_resp, wr_act, sel_m0, sel_m1;
    assign st_rd_addr = (state_q == RD_ADDR);
    assign st_rd_data = (state_q == RD_DATA);
    assign st_wr_resp = (state_q == WR_RESP);
    assign wr_act     = (state_q == WR_REQ) && (kind_q == KIND_WR);
    assign sel_m0     = (gnt_q == GNT_M0);
    assign sel_m1     = (gnt_q == GNT_M1);

    // Read address channel
    assign S_AR_VALID  = st_rd_addr && (sel_m1 ? M1_AR_VALID : M0_AR_VALID);
    assign S_AR_ADDR   = st_rd_addr ? (sel_m1 ? M1_AR_ADDR : M0_AR_ADDR) : '0;
    assign M0_AR_READY = st_rd_addr && sel_m0 && S_AR_READY;
    assign M1_AR_READY = st_rd_addr && sel_m1 && S_AR_READY;

    // Read data channel; the ungranted master sees zero valid and data
    assign S_R_READY   = st_rd_data && (sel_m1 ? M1_R_READY : M0_R_READY);
    assign M0_R_VALID  = st_rd_data && sel_m0 && S_R_VALID;
    assign M1_R_VALID  = st_rd_data && sel_m1 && S_R_VALID;
    assign M0_R_DATA   = (st_rd_data && sel_m0) ? S_R_DATA : '0;
    assign M1_R_DATA   = (st_rd_data && sel_m1) ? S_R_DATA : '0;

    // Write address/data: a channel whose handshake already happened is masked off
    assign S_AW_VALID  = wr_act && !aw_done_q && M1_AW_VALID;
    assign S_AW_ADDR   = wr_act ? M1_AW_ADDR : '0;
    assign M1_AW_READY = wr_act && !aw_done_q && S_AW_READY;
    assign S_W_VALID   = wr_act && !w_done_q && M1_W_VALID;
    assign S_W_DATA    = wr_act ? M1_W_DATA : '0;
    assign S_W_STRB    = wr_act ? M1_W_STRB : '0;
    assign M1_W_READY  = wr_act && !w_done_q && S_W_READY;

    // Write response
    assign M1_B_VALID  = st_wr_resp && S_B_VALID;
    assign S_B_READY   = st_wr_resp && M1_B_READY;

    assign GNT = gnt_q;

    // Include this cycle's handshake so both-in-one-cycle exits WR_REQ immediately.
    assign aw_done_d = aw_done_q | (S_AW_VALID && S_AW_READY);
    assign w_done_d  = w_done_q  | (S_W_VALID && S_W_READY);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q   <= IDLE;
            gnt_q     <= GNT_M0;
            kind_q    <= KIND_RD;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
`ifdef ARB_RR_EN
            ptr_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (|pick_gnt) begin
                        gnt_q   <= pick_gnt[1] ? GNT_M1 : GNT_M0;
                        kind_q  <= kind_d;
                        state_q <= (kind_d == KIND_WR) ? WR_REQ : RD_ADDR;
`ifdef ARB_RR_EN
                        // Prefer the master that did not just win.
                        ptr_q   <= pick_gnt[0];
`endif
                    end
                end
                RD_ADDR: begin
                    if (S_AR_VALID && S_AR_READY) begin
                        state_q <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (S_R_VALID && S_R_READY) begin
                        state_q <= IDLE;
                    end
                end
                WR_REQ: begin
                    aw_done_q <= aw_done_d;
                    w_done_q  <= w_done_d;
                    if (aw_done_d && w_done_d) begin
                        state_q <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (M1_B_VALID && M1_B_READY) begin
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
